// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Define TIMER_STATUS_EN to map a STATUS register (state code + W1C irq flag) at offset 3.
module timer_dev #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        PClk,
  input  logic        Reset,
  input  logic        Sel,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        IRQ
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CNT  = 3'd2,
    S_INT  = 3'd3
  } state_e;

  localparam logic [31:0] PS_LAST = 32'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [31:0] prescale_q, prescale_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q;

  logic        enable, tick, expire;
  logic        wr_ctrl, wr_preset, status_clr;
  logic        do_load, do_tick, do_dec, hw_set, hw_clr_en, auto_clr;

  // Bus access: a transfer occurs in any cycle with Sel=1; writes commit at the
  // next rising edge when WE=1, reads return RData in the same cycle, no stalls.
  assign wr_ctrl   = Sel & WE & (Addr == 2'd0);
  assign wr_preset = Sel & WE & (Addr == 2'd1);
`ifdef TIMER_STATUS_EN
  assign status_clr = Sel & WE & (Addr == 2'd3) & WData[0];
`else
  assign status_clr = 1'b0;
`endif

  assign enable = ctrl_q[0];
  assign tick   = (prescale_q == PS_LAST);
  assign expire = tick && (count_q <= 32'd1);

  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_LOAD;
      S_LOAD: state_d = S_CNT;
      S_CNT: begin
        if (!enable)     state_d = S_IDLE;
        else if (expire) state_d = S_INT;
      end
      S_INT:   state_d = (ctrl_q[2:1] == 2'd1) ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    do_load   = (state_q == S_LOAD);
    do_tick   = (state_q == S_CNT) && enable;
    do_dec    = do_tick && tick;
    hw_set    = do_dec && (count_q <= 32'd1);
    hw_clr_en = (state_q == S_INT) && (ctrl_q[2:1] != 2'd1);
    auto_clr  = (state_q == S_INT) && (ctrl_q[2:1] == 2'd1);
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (hw_clr_en) ctrl_d[0] = 1'b0;
    if (wr_ctrl)   ctrl_d = WData[3:0];

    preset_d = wr_preset ? WData : preset_q;

    count_d = count_q;
    if (do_load)     count_d = preset_q;
    else if (do_dec) count_d = (count_q <= 32'd1) ? 32'd0 : count_q - 32'd1;

    prescale_d = prescale_q;
    if (do_load)      prescale_d = 32'd0;
    else if (do_tick) prescale_d = tick ? 32'd0 : prescale_q + 32'd1;

    // A hardware set in the same cycle as any clear must win.
    irq_flag_d = irq_flag_q;
    if (wr_ctrl || wr_preset || status_clr || auto_clr) irq_flag_d = 1'b0;
    if (hw_set) irq_flag_d = 1'b1;
  end

  always_ff @(posedge PClk or posedge Reset) begin
    if (Reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      prescale_q <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_q & ctrl_q[3];
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    RData = 32'd0;
    if (Sel) begin
      case (Addr)
        2'd0: RData = {28'd0, ctrl_q};
        2'd1: RData = preset_q;
        2'd2: RData = count_q;
`ifdef TIMER_STATUS_EN
        2'd3: RData = {27'd0, state_q, 1'b0, irq_flag_q};
`else
        2'd3: RData = 32'd0;
`endif
        default: RData = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: randomized presets checked against an
// arithmetic timeline model of the countdown, reload period and IRQ timing.
module tb_timer_dev;
  localparam int PS = 1;

  logic        PClk, Reset, Sel, WE;
  logic [1:0]  Addr;
  logic [31:0] WData, RData;
  logic        IRQ;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_cnt = 32'd0;

  timer_dev #(.PRESCALE(PS)) dut (
    .PClk(PClk), .Reset(Reset), .Sel(Sel), .Addr(Addr), .WE(WE),
    .WData(WData), .RData(RData), .IRQ(IRQ)
  );

  initial PClk = 1'b0;
  always #5 PClk = ~PClk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge PClk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    Sel = 1'b1; WE = 1'b1; Addr = a; WData = d;
    @(posedge PClk);
    #1;
    Sel = 1'b0; WE = 1'b0; Addr = 2'd0; WData = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Sel = 1'b1; WE = 1'b0; Addr = a;
    #1;
    d = RData;
    Sel = 1'b0; Addr = 2'd0;
  endtask

  task automatic test_reset_initial();
    logic [31:0] d;
    Reset = 1'b1; Sel = 1'b0; WE = 1'b0; Addr = 2'd0; WData = 32'd0;
    #3;
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset0_irq got=%0b exp=0", IRQ); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset0_read off=%0d got=%0h exp=0", a, d); end
    end
    @(posedge PClk);
    #1;
    Reset = 1'b0;
    step();
  endtask

  // One-shot run: the model places every event relative to the CTRL write edge.
  task automatic test_one_shot(input int p);
    logic [31:0] d, exp_c;
    logic        exp_i;
    int          ke;
    ke = 2 + ((p == 0) ? 1 : p) * PS;
    cpu_write(2'd1, 32'(p));
    cpu_write(2'd0, 32'h9);
    for (int k = 1; k <= ke + 3; k++) begin
      step();
      if (k < 2)        exp_c = last_cnt;
      else if (k >= ke) exp_c = 32'd0;
      else              exp_c = 32'(p - (k - 2) / PS);
      exp_i = (k >= ke + 1);
      rd(2'd2, d);
      checks++; if (d !== exp_c) begin failures++; $display("FAIL one_shot_count p=%0d k=%0d got=%0h exp=%0h", p, k, d, exp_c); end
      checks++; if (IRQ !== exp_i) begin failures++; $display("FAIL one_shot_irq p=%0d k=%0d got=%0b exp=%0b", p, k, IRQ, exp_i); end
    end
    rd(2'd0, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL one_shot_ctrl p=%0d got=%0h exp=8", p, d); end
    step();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL one_shot_irq_hold p=%0d got=%0b exp=1", p, IRQ); end
    cpu_write(2'd0, 32'h0);
    step();
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL one_shot_irq_clear p=%0d got=%0b exp=0", p, IRQ); end
    last_cnt = 32'd0;
  endtask

  task automatic test_auto_reload(input int p);
    logic [31:0] d, exp_c, frozen;
    logic        exp_i;
    int          t, f, phase;
    t = p * PS + 2;
    f = t + 1;
    cpu_write(2'd1, 32'(p));
    cpu_write(2'd0, 32'hB);
    for (int k = 1; k <= 3 * t + 2; k++) begin
      step();
      phase = (k - 2) % t;
      if (k < 2)               exp_c = last_cnt;
      else if (phase <= p * PS) exp_c = 32'(p - phase / PS);
      else                     exp_c = 32'd0;
      exp_i = (k >= f) && (((k - f) % t) == 0);
      rd(2'd2, d);
      checks++; if (d !== exp_c) begin failures++; $display("FAIL reload_count p=%0d k=%0d got=%0h exp=%0h", p, k, d, exp_c); end
      checks++; if (IRQ !== exp_i) begin failures++; $display("FAIL reload_irq p=%0d k=%0d got=%0b exp=%0b", p, k, IRQ, exp_i); end
    end
    frozen = 32'(p - 1 / PS);
    cpu_write(2'd0, 32'h8);
    for (int k = 0; k < 6; k++) begin
      rd(2'd2, d);
      checks++; if (d !== frozen) begin failures++; $display("FAIL reload_frozen p=%0d k=%0d got=%0h exp=%0h", p, k, d, frozen); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reload_no_pulse p=%0d k=%0d got=%0b exp=0", p, k, IRQ); end
      step();
    end
`ifdef TIMER_STATUS_EN
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reload_status_idle got=%0h exp=0", d); end
`endif
    last_cnt = frozen;
  endtask

  task automatic test_mask();
    logic [31:0] d, exp_c;
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_c = (k < 2) ? last_cnt : ((k >= 3) ? 32'd0 : 32'd1);
      rd(2'd2, d);
      checks++; if (d !== exp_c) begin failures++; $display("FAIL mask_count k=%0d got=%0h exp=%0h", k, d, exp_c); end
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL mask_irq k=%0d got=%0b exp=0", k, IRQ); end
    end
    rd(2'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mask_ctrl got=%0h exp=0", d); end
`ifdef TIMER_STATUS_EN
    rd(2'd3, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL mask_status_set got=%0h exp=1", d); end
`endif
    cpu_write(2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL mask_irq_after k=%0d got=%0b exp=0", k, IRQ); end
      step();
    end
`ifdef TIMER_STATUS_EN
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mask_status_clr got=%0h exp=0", d); end
`endif
    cpu_write(2'd0, 32'h0);
    last_cnt = 32'd0;
  endtask

  task automatic test_status();
    logic [31:0] d;
    cpu_write(2'd1, 32'd2);
    cpu_write(2'd0, 32'h9);
    for (int k = 0; k < 6; k++) step();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL status_pre_irq got=%0b exp=1", IRQ); end
`ifdef TIMER_STATUS_EN
    rd(2'd3, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL status_read got=%0h exp=1", d); end
    cpu_write(2'd3, 32'h1);
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL status_irq_lag got=%0b exp=1", IRQ); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL status_w1c got=%0h exp=0", d); end
    step();
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL status_irq_drop got=%0b exp=0", IRQ); end
`else
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL off3_read got=%0h exp=0", d); end
    cpu_write(2'd3, 32'hF);
    step();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL off3_write_ignored got=%0b exp=1", IRQ); end
    rd(2'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL off3_read_after got=%0h exp=0", d); end
`endif
    rd(2'd0, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL status_ctrl_kept got=%0h exp=8", d); end
    cpu_write(2'd0, 32'h0);
    step();
    last_cnt = 32'd0;
  endtask

  // CPU writes colliding with hardware events at the expiry and INT edges.
  task automatic test_simultaneous();
    logic [31:0] d;
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'h9);
    step();
    step();
    cpu_write(2'd1, 32'd1);
    cpu_write(2'd0, 32'h9);
    rd(2'd0, d);
    checks++; if (d !== 32'h9) begin failures++; $display("FAIL simul_ctrl_wins got=%0h exp=9", d); end
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL simul_set_wins got=%0b exp=1", IRQ); end
    step();
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL simul_flag_cleared got=%0b exp=0", IRQ); end
    step();
    rd(2'd2, d);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL simul_reload got=%0h exp=1", d); end
    step();
    step();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL simul_second_irq got=%0b exp=1", IRQ); end
    cpu_write(2'd0, 32'h0);
    step();
    last_cnt = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cpu_write(2'd1, 32'd5);
    cpu_write(2'd0, 32'hB);
    for (int k = 0; k < 8; k++) step();
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL reset_pre_irq got=%0b exp=1", IRQ); end
    #1;
    Reset = 1'b1;
    #1;
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_async_irq got=%0b exp=0", IRQ); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_read off=%0d got=%0h exp=0", a, d); end
    end
    step();
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rd(2'd2, d);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_stays_idle got=%0h exp=0", d); end
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq_idle got=%0b exp=0", IRQ); end
  endtask

  initial begin
    test_reset_initial();
    test_one_shot(3);
    test_one_shot(0);
    for (int i = 0; i < 3; i++) test_one_shot(int'($urandom_range(0, 6)));
    test_auto_reload(2);
    test_auto_reload(int'($urandom_range(2, 5)));
    test_one_shot(int'($urandom_range(1, 6)));
    test_mask();
    test_status();
    test_simultaneous();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
